// File: rtl/ram_bank_ring.sv
// ram_bank_ring: N-bank circular frame buffer.
// The writer fills banks in ring order. A bank is committed when it holds
// DEPTH samples or when write_last_i arrives with an accepted beat. The reader
// drains committed banks in commit order through a zero-latency show-ahead port.
//
// Handshake semantics, on both ports: a beat transfers on a rising clock edge
// exactly when valid and ready are both high in the cycle before it. The
// producer holds data while valid is high and ready is low. read_data_o is
// stable while read_valid_o is high and read_ready_i is low. With
// DROP_ON_FULL=1, write_ready_o stays high, but beats offered while every bank
// is committed are discarded instead of stored.
module ram_bank_ring #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 16,
  parameter int NUM_BANKS    = 3,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int DROP_ON_FULL = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic signed [WIDTH-1:0]          write_data_i,
  input  logic                             write_valid_i,
  input  logic                             write_last_i,
  output logic                             write_ready_o,
  output logic signed [WIDTH-1:0]          read_data_o,
  output logic                             read_valid_o,
  input  logic                             read_ready_i,
  output logic                             read_last_o,
  output logic [ADDR_WIDTH:0]              read_len_o,
  output logic [$clog2(NUM_BANKS+1)-1:0]   banks_full_o,
  output logic                             buffer_ready_o,
  output logic                             buffer_overflow_o,
  input  logic                             overflow_clr_i,
  output logic [ADDR_WIDTH:0]              write_count_o,
  output logic [ADDR_WIDTH:0]              read_count_o
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int FW = $clog2(NUM_BANKS + 1);
  localparam int BW = $clog2(NUM_BANKS);

  localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
  localparam logic [FW-1:0] FULL_LVL  = FW'(NUM_BANKS);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  // Sample storage; contents are deliberately left unreset.
  logic signed [WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];
  // Committed length of each bank (1..DEPTH).
  logic [CW-1:0]           r_len [NUM_BANKS];

  logic [BW-1:0] r_wr_bank;
  logic [BW-1:0] r_rd_bank;
  logic [CW-1:0] r_wr_count;
  logic [CW-1:0] r_rd_count;
  logic [FW-1:0] r_banks_full;
  logic          r_overflow;

  logic          w_not_full;
  logic          w_wr_accept;
  logic          w_commit;
  logic          w_rd_valid;
  logic [CW-1:0] w_rd_len;
  logic          w_rd_last;
  logic          w_rd_xfer;
  logic          w_release;
  logic          w_overflow_set;

  // Ring successor of a bank index; NUM_BANKS need not be a power of two.
  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + BW'(1);
  endfunction

  assign w_not_full     = (r_banks_full < FULL_LVL);
  assign write_ready_o  = (DROP_ON_FULL != 0) ? 1'b1 : w_not_full;
  assign w_wr_accept    = write_valid_i & write_ready_o & w_not_full;
  assign w_commit       = w_wr_accept & (write_last_i | (r_wr_count == LAST_IDX));
  // Any beat offered while every bank holds unread data is an overflow, in both modes.
  assign w_overflow_set = write_valid_i & ~w_not_full;

  assign w_rd_valid     = (r_banks_full != '0);
  assign w_rd_len       = r_len[r_rd_bank];
  assign w_rd_last      = w_rd_valid & (r_rd_count == (w_rd_len - CW'(1)));
  assign w_rd_xfer      = w_rd_valid & read_ready_i;
  assign w_release      = w_rd_xfer & w_rd_last;

  assign read_valid_o      = w_rd_valid;
  assign read_data_o       = r_mem[r_rd_bank][r_rd_count[ADDR_WIDTH-1:0]];
  assign read_last_o       = w_rd_last;
  assign read_len_o        = w_rd_len;
  assign banks_full_o      = r_banks_full;
  assign buffer_ready_o    = w_rd_valid;
  assign buffer_overflow_o = r_overflow;
  assign write_count_o     = r_wr_count;
  assign read_count_o      = r_rd_count;

  // Store accepted samples into the open write bank.
  always_ff @(posedge clk_i) begin
    if (w_wr_accept) begin
      r_mem[r_wr_bank][r_wr_count[ADDR_WIDTH-1:0]] <= write_data_i;
    end
  end

  // Write pointer, fill count and per-bank committed length.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_bank  <= '0;
      r_wr_count <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_len[b] <= '0;
      end
    end else if (w_commit) begin
      r_len[r_wr_bank] <= r_wr_count + CW'(1);
      r_wr_bank        <= next_bank(r_wr_bank);
      r_wr_count       <= '0;
    end else if (w_wr_accept) begin
      r_wr_count <= r_wr_count + CW'(1);
    end
  end

  // Read pointer and position within the bank being drained.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_bank  <= '0;
      r_rd_count <= '0;
    end else if (w_release) begin
      r_rd_bank  <= next_bank(r_rd_bank);
      r_rd_count <= '0;
    end else if (w_rd_xfer) begin
      r_rd_count <= r_rd_count + CW'(1);
    end
  end

  // Committed-bank occupancy; a simultaneous commit and release cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_banks_full <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_banks_full <= r_banks_full + FW'(1);
        2'b01:   r_banks_full <= r_banks_full - FW'(1);
        default: r_banks_full <= r_banks_full;
      endcase
    end
  end

  // Sticky overflow flag; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_overflow <= 1'b0;
    end else if (w_overflow_set) begin
      r_overflow <= 1'b1;
    end else if (overflow_clr_i) begin
      r_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_bank_ring.sv
// Testbench for ram_bank_ring. It drives two instances: dut0 applies
// backpressure when full, and dut1 drops beats when full. A select signal
// routes the shared stimulus to one instance and muxes its outputs back.
module tb_ram_bank_ring;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int NB    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FW    = $clog2(NB + 1);

  logic clk;
  logic rst_n;
  logic sel;
  logic [WIDTH-1:0] wd;
  logic wv, wl, rr, oc;

  logic signed [WIDTH-1:0] o0_data, o1_data;
  logic o0_valid, o1_valid, o0_last, o1_last, o0_wready, o1_wready;
  logic o0_bready, o1_bready, o0_ovf, o1_ovf;
  logic [CW-1:0] o0_len, o1_len, o0_wcnt, o1_wcnt, o0_rcnt, o1_rcnt;
  logic [FW-1:0] o0_full, o1_full;

  logic [WIDTH-1:0] m_data;
  logic m_valid, m_last, m_wready, m_ovf;
  logic [CW-1:0] m_len, m_wcnt;
  logic [FW-1:0] m_full;

  logic [WIDTH:0] exp_q[$];
  int tests_run = 0;
  int failed = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ram_bank_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(NB), .DROP_ON_FULL(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .write_data_i(wd), .write_valid_i(wv & ~sel), .write_last_i(wl), .write_ready_o(o0_wready),
    .read_data_o(o0_data), .read_valid_o(o0_valid), .read_ready_i(rr & ~sel),
    .read_last_o(o0_last), .read_len_o(o0_len), .banks_full_o(o0_full),
    .buffer_ready_o(o0_bready), .buffer_overflow_o(o0_ovf), .overflow_clr_i(oc & ~sel),
    .write_count_o(o0_wcnt), .read_count_o(o0_rcnt)
  );

  ram_bank_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(NB), .DROP_ON_FULL(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .write_data_i(wd), .write_valid_i(wv & sel), .write_last_i(wl), .write_ready_o(o1_wready),
    .read_data_o(o1_data), .read_valid_o(o1_valid), .read_ready_i(rr & sel),
    .read_last_o(o1_last), .read_len_o(o1_len), .banks_full_o(o1_full),
    .buffer_ready_o(o1_bready), .buffer_overflow_o(o1_ovf), .overflow_clr_i(oc & sel),
    .write_count_o(o1_wcnt), .read_count_o(o1_rcnt)
  );

  assign m_data   = sel ? o1_data   : o0_data;
  assign m_valid  = sel ? o1_valid  : o0_valid;
  assign m_last   = sel ? o1_last   : o0_last;
  assign m_wready = sel ? o1_wready : o0_wready;
  assign m_ovf    = sel ? o1_ovf    : o0_ovf;
  assign m_len    = sel ? o1_len    : o0_len;
  assign m_wcnt   = sel ? o1_wcnt   : o0_wcnt;
  assign m_full   = sel ? o1_full   : o0_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every read transfer is compared with the queue head
  always @(negedge clk) begin
    if (rst_n && m_valid && rr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read_beat", {31'd0, m_valid}, 32'd0);
      end else begin
        logic [WIDTH:0] e;
        e = exp_q.pop_front();
        check("read_data", m_data, e[WIDTH-1:0]);
        check("read_last", {31'd0, m_last}, {31'd0, e[WIDTH]});
      end
    end
  end

  // driver tasks; each starts and ends at 1 time unit after a rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [WIDTH-1:0] d, input logic l);
    int n;
    n = 0;
    wd = d; wl = l; wv = 1'b1;
    @(negedge clk);
    while (!m_wready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!m_wready) check("write_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    wv = 1'b0; wl = 1'b0;
  endtask

  // write one bank of len beats, data = base+i, optionally scoreboarded
  task automatic write_bank(input logic [WIDTH-1:0] base, input int len, input bit push);
    for (int i = 0; i < len; i++) begin
      if (push) exp_q.push_back({(i == len - 1), base + WIDTH'(i)});
      write_beat(base + WIDTH'(i), (i == len - 1) && (len < DEPTH));
    end
  endtask

  task automatic read_one_bank();
    int n;
    n = 0;
    rr = 1'b1;
    @(negedge clk);
    while (!(m_valid && m_last) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(m_valid && m_last)) check("read_bank_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rr = 1'b1;
    @(negedge clk);
    while (m_full != '0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", {30'd0, m_full}, 32'd0);
    @(posedge clk);
    #1;
    rr = 1'b0;
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b0; wd = '0; wv = 1'b0; wl = 1'b0; rr = 1'b0; oc = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_wcount", {27'd0, m_wcnt}, 32'd0);
    check("rst_full", {30'd0, m_full}, 32'd0);
    check("rst_rvalid", {31'd0, m_valid}, 32'd0);
    check("rst_wready", {31'd0, m_wready}, 32'd1);
    check("rst_ovf", {31'd0, m_ovf}, 32'd0);
    check("rst_wready_drop", {31'd0, o1_wready}, 32'd1);
    sync();

    // reset mid-fill
    for (int i = 0; i < 5; i++) write_beat(32'h10 + i, 1'b0);
    @(negedge clk);
    check("midfill_wcount", {27'd0, m_wcnt}, 32'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_wcount", {27'd0, m_wcnt}, 32'd0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_wcount", {27'd0, m_wcnt}, 32'd0);
    check("postrst_full", {30'd0, m_full}, 32'd0);
    check("postrst_rvalid", {31'd0, m_valid}, 32'd0);
    check("postrst_wready", {31'd0, m_wready}, 32'd1);
    sync();

    // full bank of 16 beats
    write_bank(32'h1000, 16, 1'b1);
    @(negedge clk);
    check("b16_full", {30'd0, m_full}, 32'd1);
    check("b16_len", {27'd0, m_len}, 32'd16);
    check("b16_rvalid", {31'd0, m_valid}, 32'd1);
    check("b16_wcount", {27'd0, m_wcnt}, 32'd0);
    sync();
    drain();

    // short bank closed by write_last_i, followed by a full bank
    write_bank(32'h2000, 5, 1'b1);
    @(negedge clk);
    check("b5_len", {27'd0, m_len}, 32'd5);
    check("b5_full", {30'd0, m_full}, 32'd1);
    sync();
    write_bank(32'h2100, 16, 1'b1);
    @(negedge clk);
    check("b5b16_full", {30'd0, m_full}, 32'd2);
    sync();
    drain();

    // backpressure mode: fill every bank
    for (int b = 0; b < NB; b++) write_bank(32'h3000 + 32'(b * 16), 16, 1'b1);
    @(negedge clk);
    check("bp_full", {30'd0, m_full}, 32'd3);
    check("bp_wready", {31'd0, m_wready}, 32'd0);
    check("bp_ovf_before", {31'd0, m_ovf}, 32'd0);
    sync();
    wd = 32'hBAD; wv = 1'b1;
    sync();
    wv = 1'b0;
    @(negedge clk);
    check("bp_ovf_set", {31'd0, m_ovf}, 32'd1);
    check("bp_wcount", {27'd0, m_wcnt}, 32'd0);
    sync();
    read_one_bank();
    @(negedge clk);
    check("bp_full_after_read", {30'd0, m_full}, 32'd2);
    check("bp_wready_back", {31'd0, m_wready}, 32'd1);
    sync();
    oc = 1'b1;
    sync();
    oc = 1'b0;
    @(negedge clk);
    check("bp_ovf_clr", {31'd0, m_ovf}, 32'd0);
    sync();
    drain();

    // drop mode: extra beats while full are discarded
    sel = 1'b1;
    for (int b = 0; b < NB; b++) write_bank(32'h4000 + 32'(b * 16), 16, 1'b1);
    @(negedge clk);
    check("drop_full", {30'd0, m_full}, 32'd3);
    check("drop_wready", {31'd0, m_wready}, 32'd1);
    sync();
    for (int i = 0; i < 4; i++) write_beat(32'hDEAD, 1'b0);
    @(negedge clk);
    check("drop_wcount", {27'd0, m_wcnt}, 32'd0);
    check("drop_full_kept", {30'd0, m_full}, 32'd3);
    check("drop_ovf", {31'd0, m_ovf}, 32'd1);
    sync();
    // set and clear in the same cycle: set wins
    wd = 32'hDEAD; wv = 1'b1; oc = 1'b1;
    sync();
    wv = 1'b0; oc = 1'b0;
    @(negedge clk);
    check("drop_set_wins", {31'd0, m_ovf}, 32'd1);
    sync();
    drain();
    @(negedge clk);
    check("drop_ovf_sticky", {31'd0, m_ovf}, 32'd1);
    sync();
    oc = 1'b1;
    sync();
    oc = 1'b0;
    @(negedge clk);
    check("drop_ovf_clr", {31'd0, m_ovf}, 32'd0);
    sync();

    // concurrent stream: reader always ready, five banks back-to-back
    sel = 1'b0;
    rr = 1'b1;
    for (int b = 0; b < 5; b++) write_bank(32'h5000 + 32'(b * 16), 16, 1'b1);
    drain();
    @(negedge clk);
    check("stream_ovf", {31'd0, m_ovf}, 32'd0);
    check("stream_wcount", {27'd0, m_wcnt}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
